// File: rtl/vga_palette_ctrl.sv
// rtl/vga_palette_ctrl.sv - single-clock VGA scan-out with index FIFO and writable palette
module vga_palette_ctrl #(
  parameter int PAL_BITS   = 3,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33
) (
  input  logic                   clk_100mhz_buf,
  input  logic                   rst,
  input  logic [PAL_BITS-1:0]    pix_index,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic                   pal_we,
  input  logic [PAL_BITS-1:0]    pal_addr,
  input  logic [3*COLOR_W-1:0]   pal_wdata,
  input  logic                   underflow_clr,
  output logic                   underflow,
  output logic                   frame_start,
  output logic                   blank,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   comp_sync,
  output logic [COLOR_W-1:0]     pixel_r,
  output logic [COLOR_W-1:0]     pixel_g,
  output logic [COLOR_W-1:0]     pixel_b
);

  localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW       = $clog2(HT);
  localparam int VW       = $clog2(VT);
  localparam int DW       = $clog2(CLK_DIV);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int PAL_N    = 1 << PAL_BITS;
  localparam int RGB_W    = 3 * COLOR_W;
  localparam int CH_SHIFT = (COLOR_W >= 8) ? 0 : 8 - COLOR_W;

  logic [DW-1:0] div;
  logic [HW-1:0] hc;
  logic [VW-1:0] vc;
  logic          pe;
  logic          active;
  logic          hs_win;
  logic          vs_win;

  assign pe     = (div == DW'(CLK_DIV - 1));
  assign active = (32'(hc) < H_ACTIVE) && (32'(vc) < V_ACTIVE);
  assign hs_win = (32'(hc) >= H_ACTIVE + H_FP) && (32'(hc) < H_ACTIVE + H_FP + H_SYNC);
  assign vs_win = (32'(vc) >= V_ACTIVE + V_FP) && (32'(vc) < V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      div <= '0;
      hc  <= '0;
      vc  <= '0;
    end else if (pe) begin
      div <= '0;
      if (hc == HW'(HT - 1)) begin
        hc <= '0;
        vc <= (vc == VW'(VT - 1)) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  // Index FIFO; pointers wrap naturally because the depth is a power of two.
  logic [PAL_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign pix_ready = ~full;
  assign push      = pix_valid & ~full;
  assign pop       = pe & active & ~empty;

  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk_100mhz_buf) begin
    if (push) fifo_mem[wr_ptr] <= pix_index;
  end

  function automatic logic [COLOR_W-1:0] chan(input logic [7:0] v);
    logic [31:0] t;
    t = {24'd0, v} >> CH_SHIFT;
    return t[COLOR_W-1:0];
  endfunction

  function automatic logic [RGB_W-1:0] pal_default(input int i);
    logic [23:0] c;
    case (i)
      1:       c = 24'h00FF00;
      2:       c = 24'h0000FF;
      3:       c = 24'hFF0000;
      4:       c = 24'h66FFFF;
      5:       c = 24'hD3D3D3;
      6:       c = 24'hFFFFFF;
      7:       c = 24'hCCFF99;
      default: c = 24'h000000;
    endcase
    return {chan(c[23:16]), chan(c[15:8]), chan(c[7:0])};
  endfunction

  logic [RGB_W-1:0] pal [PAL_N];

  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      for (int i = 0; i < PAL_N; i++) pal[i] <= pal_default(i);
    end else if (pal_we) begin
      pal[pal_addr] <= pal_wdata;
    end
  end

  // Lookup reads the pre-edge palette, so a same-cycle write is seen on the next pixel.
  logic [RGB_W-1:0] rgb_next;
  logic [RGB_W-1:0] rgb_q;

  assign rgb_next = !active ? '0 : (empty ? pal[0] : pal[fifo_mem[rd_ptr]]);
  assign pixel_r  = rgb_q[3*COLOR_W-1 -: COLOR_W];
  assign pixel_g  = rgb_q[2*COLOR_W-1 -: COLOR_W];
  assign pixel_b  = rgb_q[COLOR_W-1:0];

  always_ff @(posedge clk_100mhz_buf) begin
    if (rst) begin
      blank       <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      comp_sync   <= 1'b1;
      rgb_q       <= '0;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      frame_start <= pe && (hc == '0) && (vc == '0);
      if (pe) begin
        blank     <= active;
        hsync     <= ~hs_win;
        vsync     <= ~vs_win;
        comp_sync <= ~hs_win & ~vs_win;
        rgb_q     <= rgb_next;
      end
      if (pe && active && empty) underflow <= 1'b1;
      else if (underflow_clr)    underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_palette_ctrl.sv
// tb/tb_vga_palette_ctrl.sv - directed self-checking bench for vga_palette_ctrl
module tb_vga_palette_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] pix_index = '0;
  logic       pix_valid = 1'b0;
  logic       pix_ready;
  logic       pal_we = 1'b0;
  logic [2:0] pal_addr = '0;
  logic [23:0] pal_wdata = '0;
  logic       underflow_clr = 1'b0;
  logic       underflow, frame_start, blank, hsync, vsync, comp_sync;
  logic [7:0] pixel_r, pixel_g, pixel_b;
  logic [23:0] rgb;

  int checks = 0;
  int passed = 0;

  assign rgb = {pixel_r, pixel_g, pixel_b};

  always #5 clk = ~clk;

  vga_palette_ctrl #(
    .PAL_BITS(3), .COLOR_W(8), .FIFO_DEPTH(16), .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk_100mhz_buf(clk), .rst(rst),
    .pix_index(pix_index), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
    .underflow_clr(underflow_clr), .underflow(underflow), .frame_start(frame_start),
    .blank(blank), .hsync(hsync), .vsync(vsync), .comp_sync(comp_sync),
    .pixel_r(pixel_r), .pixel_g(pixel_g), .pixel_b(pixel_b)
  );

  function automatic logic [23:0] def_color(input int i);
    case (i)
      1:       return 24'h00FF00;
      2:       return 24'h0000FF;
      3:       return 24'hFF0000;
      4:       return 24'h66FFFF;
      5:       return 24'hD3D3D3;
      6:       return 24'hFFFFFF;
      7:       return 24'hCCFF99;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pix_valid = 1'b0;
    pal_we = 1'b0;
    underflow_clr = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    int n;
    do_reset();
    checks++; if (pix_ready !== 1'b1) $display("FAIL rst_pix_ready: got %b expected 1", pix_ready); else passed++;
    checks++; if (blank !== 1'b0) $display("FAIL rst_blank: got %b expected 0", blank); else passed++;
    checks++; if (hsync !== 1'b1) $display("FAIL rst_hsync: got %b expected 1", hsync); else passed++;
    checks++; if (vsync !== 1'b1) $display("FAIL rst_vsync: got %b expected 1", vsync); else passed++;
    checks++; if (comp_sync !== 1'b1) $display("FAIL rst_comp_sync: got %b expected 1", comp_sync); else passed++;
    checks++; if (rgb !== 24'h0) $display("FAIL rst_rgb: got %h expected 000000", rgb); else passed++;
    checks++; if (frame_start !== 1'b0) $display("FAIL rst_frame_start: got %b expected 0", frame_start); else passed++;
    checks++; if (underflow !== 1'b0) $display("FAIL rst_underflow: got %b expected 0", underflow); else passed++;
    rst = 1'b0;
    step();
    checks++; if (frame_start !== 1'b0) $display("FAIL frame_start_cycle1: got %b expected 0", frame_start); else passed++;
    step();
    checks++; if (frame_start !== 1'b1) $display("FAIL frame_start_cycle2: got %b expected 1", frame_start); else passed++;
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 400);
    checks++; if (n != 196) $display("FAIL frame_period: got %0d expected 196", n); else passed++;
  endtask

  task automatic test_sync_blank();
    int hx, vy, be, he, ve, ce, fe, bhi;
    logic eb, ehs, evs;
    be = 0; he = 0; ve = 0; ce = 0; fe = 0; bhi = 0;
    for (int k = 0; k < 196; k++) begin
      hx = k % 14;
      vy = (k / 14) % 7;
      eb  = (hx < 8) && (vy < 4);
      ehs = !(hx >= 10 && hx < 12);
      evs = (vy != 5);
      if (blank !== eb) be++;
      if (hsync !== ehs) he++;
      if (vsync !== evs) ve++;
      if (comp_sync !== (ehs & evs)) ce++;
      if (frame_start !== (k % 98 == 0)) fe++;
      if (blank === 1'b1) bhi++;
      step();
      step();
    end
    checks++; if (be != 0) $display("FAIL sync_blank: got %0d bad pixels expected 0", be); else passed++;
    checks++; if (he != 0) $display("FAIL sync_hsync: got %0d bad pixels expected 0", he); else passed++;
    checks++; if (ve != 0) $display("FAIL sync_vsync: got %0d bad pixels expected 0", ve); else passed++;
    checks++; if (ce != 0) $display("FAIL sync_comp_sync: got %0d bad pixels expected 0", ce); else passed++;
    checks++; if (fe != 0) $display("FAIL sync_frame_start: got %0d bad pixels expected 0", fe); else passed++;
    checks++; if (bhi != 64) $display("FAIL sync_visible_count: got %0d expected 64", bhi); else passed++;
  endtask

  task automatic test_streaming();
    int mcount, npush, npop, rdy_err, rgb_err, k;
    logic acc, pp, act, pe_t, saw_full, idx3_done;
    logic [23:0] exp_rgb;
    mcount = 0; npush = 0; npop = 0; rdy_err = 0; rgb_err = 0;
    saw_full = 1'b0; idx3_done = 1'b0;
    do_reset();
    for (int t = 1; t <= 400; t++) begin
      rst = 1'b0;
      pix_valid = 1'b1;
      pix_index = 3'(npush % 8);
      pe_t = (t % 2 == 0);
      k = t / 2 - 1;
      act = pe_t && (k % 14 < 8) && ((k / 14) % 7 < 4);
      acc = (mcount < 16);
      pp = act && (mcount > 0);
      step();
      if (acc) npush++;
      mcount = mcount + (acc ? 1 : 0) - (pp ? 1 : 0);
      if (pix_ready !== (mcount < 16)) rdy_err++;
      if (mcount == 16) saw_full = 1'b1;
      if (pe_t) begin
        exp_rgb = act ? (pp ? def_color(npop % 8) : def_color(0)) : 24'h0;
        if (rgb !== exp_rgb) rgb_err++;
        if (pp && (npop % 8 == 3) && !idx3_done) begin
          idx3_done = 1'b1;
          checks++; if (rgb !== 24'hFF0000) $display("FAIL stream_index3: got %h expected FF0000", rgb); else passed++;
        end
        if (pp) npop++;
      end
    end
    pix_valid = 1'b0;
    checks++; if (rgb_err != 0) $display("FAIL stream_rgb: got %0d bad pixels expected 0", rgb_err); else passed++;
    checks++; if (rdy_err != 0) $display("FAIL stream_pix_ready: got %0d bad cycles expected 0", rdy_err); else passed++;
    checks++; if (saw_full !== 1'b1) $display("FAIL stream_full_reached: got %b expected 1", saw_full); else passed++;
    checks++; if (underflow !== 1'b0) $display("FAIL stream_underflow: got %b expected 0", underflow); else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    for (int t = 1; t <= 31; t++) begin
      rst = 1'b0;
      pix_valid = (t <= 5);
      pix_index = 3'(t);
      underflow_clr = (t == 19 || t == 30);
      step();
      if (t == 2 || t == 4 || t == 6 || t == 8 || t == 10) begin
        checks++; if (rgb !== def_color(t / 2)) $display("FAIL uf_pixel_%0d: got %h expected %h", t / 2 - 1, rgb, def_color(t / 2)); else passed++;
      end
      if (t == 10) begin
        checks++; if (underflow !== 1'b0) $display("FAIL uf_before: got %b expected 0", underflow); else passed++;
      end
      if (t == 12 || t == 14 || t == 16) begin
        checks++; if (rgb !== 24'h0) $display("FAIL uf_empty_pixel_%0d: got %h expected 000000", t / 2 - 1, rgb); else passed++;
        checks++; if (underflow !== 1'b1) $display("FAIL uf_set_%0d: got %b expected 1", t, underflow); else passed++;
      end
      if (t == 19 || t == 29) begin
        checks++; if (underflow !== 1'b0) $display("FAIL uf_cleared_%0d: got %b expected 0", t, underflow); else passed++;
      end
      if (t == 30 || t == 31) begin
        checks++; if (underflow !== 1'b1) $display("FAIL uf_set_wins_%0d: got %b expected 1", t, underflow); else passed++;
      end
    end
    pix_valid = 1'b0;
    underflow_clr = 1'b0;
  endtask

  task automatic test_palette_write();
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      rst = 1'b0;
      pix_valid = (t <= 2);
      pix_index = 3'd2;
      pal_we = (t == 2);
      pal_addr = 3'd2;
      pal_wdata = 24'h123456;
      step();
      if (t == 2) begin
        checks++; if (rgb !== 24'h0000FF) $display("FAIL pal_old_value: got %h expected 0000FF", rgb); else passed++;
      end
      if (t == 4) begin
        checks++; if (rgb !== 24'h123456) $display("FAIL pal_new_value: got %h expected 123456", rgb); else passed++;
      end
    end
    pix_valid = 1'b0;
    pal_we = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int t = 1; t <= 72; t++) begin
      rst = (t == 67 || t == 68);
      pix_valid = (t >= 50 && t <= 60) || (t == 69);
      pix_index = (t == 69) ? 3'd2 : 3'd7;
      pal_we = (t == 10);
      pal_addr = 3'd2;
      pal_wdata = 24'h123456;
      step();
      if (t == 66) begin
        checks++; if (rgb !== 24'hCCFF99) $display("FAIL mid_pre_pixel: got %h expected CCFF99", rgb); else passed++;
      end
      if (t == 67) begin
        checks++; if (pix_ready !== 1'b1) $display("FAIL mid_pix_ready: got %b expected 1", pix_ready); else passed++;
        checks++; if (underflow !== 1'b0) $display("FAIL mid_underflow: got %b expected 0", underflow); else passed++;
        checks++; if (blank !== 1'b0) $display("FAIL mid_blank: got %b expected 0", blank); else passed++;
        checks++; if (rgb !== 24'h0) $display("FAIL mid_rgb: got %h expected 000000", rgb); else passed++;
      end
      if (t == 69) begin
        checks++; if (frame_start !== 1'b0) $display("FAIL mid_fs_early: got %b expected 0", frame_start); else passed++;
      end
      if (t == 70) begin
        checks++; if (frame_start !== 1'b1) $display("FAIL mid_fs_restart: got %b expected 1", frame_start); else passed++;
        checks++; if (rgb !== 24'h0000FF) $display("FAIL mid_first_pixel: got %h expected 0000FF", rgb); else passed++;
        checks++; if (blank !== 1'b1) $display("FAIL mid_first_blank: got %b expected 1", blank); else passed++;
      end
      if (t == 72) begin
        checks++; if (rgb !== 24'h0) $display("FAIL mid_second_pixel: got %h expected 000000", rgb); else passed++;
        checks++; if (underflow !== 1'b1) $display("FAIL mid_second_underflow: got %b expected 1", underflow); else passed++;
      end
    end
    pix_valid = 1'b0;
    pal_we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sync_blank();
    test_streaming();
    test_underflow();
    test_palette_write();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_palette_ctrl.md
# vga_palette_ctrl

Single-clock, parametrised VGA scan-out engine that replaces the fixed 8-colour, dual-clock controller. It accepts a ready/valid stream of palette indices from the game logic, buffers them in an internal FIFO, and resolves each index through a runtime-writable colour palette. It generates the raster timing internally from a pixel clock-enable divided down from `clk_100mhz_buf`, and drives the video DAC with sync, blank and RGB outputs.

## Interface
- `PAL_BITS`, 3: width of a palette index; the palette has 2^PAL_BITS entries.
- `COLOR_W`, 8: bits per colour channel.
- `FIFO_DEPTH`, 16: index FIFO depth; power of two, ≥ 2.
- `CLK_DIV`, 4: `clk_100mhz_buf` cycles per pixel; ≥ 2.
- `H_ACTIVE`/`H_FP`/`H_SYNC`/`H_BP`, 640/16/96/48: horizontal timing, in pixels.
- `V_ACTIVE`/`V_FP`/`V_SYNC`/`V_BP`, 480/10/2/33: vertical timing, in lines.

- `clk_100mhz_buf`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `pix_index`  in  PAL_BITS  palette index of the next pixel, in raster order.
- `pix_valid`  in  1  `pix_index` is valid.
- `pix_ready`  out  1  FIFO can accept a pixel; a push occurs when `pix_valid & pix_ready`.
- `pal_we`  in  1  palette write strobe.
- `pal_addr`  in  PAL_BITS  palette entry to write.
- `pal_wdata`  in  3*COLOR_W  entry value, packed as {r,g,b}.
- `underflow_clr`  in  1  clears `underflow`.
- `underflow`  out  1  sticky flag: a pixel was needed while the FIFO was empty.
- `frame_start`  out  1  one-cycle pulse at the start of each frame (pixel 0, line 0).
- `blank`  out  1  DAC blank, active-low: 1 = visible region.
- `hsync`, `vsync`  out  1 each  active-low syncs.
- `comp_sync`  out  1  `hsync & vsync`.
- `pixel_r`, `pixel_g`, `pixel_b`  out  COLOR_W each  colour channels.

## Operation
- **Pixel enable.** Divider counter `div` runs 0..CLK_DIV-1. Pixel enable `pe` = (`div` == CLK_DIV-1). All raster state advances only on `pe`.
- **Raster counters.**
  - `hc` counts 0..HT-1, where HT = sum of the H parameters.
  - `vc` counts 0..VT-1, where VT = sum of the V parameters; `vc` increments when `hc` wraps.
  - Regions, in order starting at 0: active, front porch, sync, back porch.
- **FIFO.**
  - `pix_ready` = !full.
  - On `pe` with (`hc`,`vc`) in the active region, one entry is popped.
  - A simultaneous push and pop is legal, including a push into an empty FIFO: the pop sees empty and the pushed data is kept.
  - Occupancy never exceeds FIFO_DEPTH.
- **Underflow.**
  - If an active-region `pe` finds the FIFO empty, the output pixel is palette entry 0 and `underflow` is set.
  - `underflow` clears only on `rst` or `underflow_clr`. If set and clear occur in the same cycle, set wins.
- **Palette.**
  - Register-based, 2^PAL_BITS × 3*COLOR_W.
  - The write takes effect at the clock edge.
  - A lookup in the same cycle as a write to the same entry returns the old value.
- **Palette reset contents** (COLOR_W=8, written as hex rrggbb):
  - Entries 0–7: 000000, 00FF00, 0000FF, FF0000, 66FFFF, D3D3D3, FFFFFF, CCFF99.
  - Entries ≥ 8: 000000.
  - For other COLOR_W, each channel takes the MSBs of the 8-bit value, zero-extended if COLOR_W > 8.
- **Outputs.**
  - On each `pe`, the output registers load values computed from the current (`hc`,`vc`): blank, hsync, vsync, comp_sync and RGB.
  - RGB = palette[popped index] in the active region, else all zeros.
  - `frame_start` pulses on the `pe` where `hc`=0 and `vc`=0.
- **Reset** (also applies mid-frame):
  - `div`, `hc`, `vc` ← 0.
  - FIFO flushed.
  - Palette restored to its reset contents.
  - `underflow` ← 0.
  - Output reset values: `pix_ready`=1, `blank`=0, `hsync`=1, `vsync`=1, `comp_sync`=1, RGB=0, `frame_start`=0.

## Timing
- **Pixel cadence.** The first `pe` occurs in the CLK_DIV-th cycle after `rst` deasserts; thereafter `pe` recurs every CLK_DIV cycles.
- **Output latency.** Outputs change only on a `pe` edge and describe the pixel that was current at that edge, i.e. a 1-`pe` pipeline from counters to pins.
- **Sync windows.**
  - `hsync` is low for H_SYNC consecutive pixels starting at `hc` = H_ACTIVE+H_FP.
  - `vsync` is low for V_SYNC whole lines starting at `vc` = V_ACTIVE+V_FP.
- **Frame length.** HT·VT·CLK_DIV clocks.
- **Input handshake.**
  - `pix_ready` is combinational from FIFO occupancy.
  - The producer must hold `pix_index` stable while `pix_valid` is high and `pix_ready` is low.

## Test plan
Benches use CLK_DIV=2, H=8/2/2/2 (HT=14), V=4/1/1/1 (VT=7) unless stated otherwise.
- **Reset state:** hold `rst` 3 cycles → all outputs at their reset values; first `frame_start` is 2 cycles after release; frames recur every 196 cycles.
- **Sync/blank timing:** measure over 2 frames → `blank` high for 8 of every 14 pixels on lines 0–3; `hsync` low at `hc` 10–11; `vsync` low on line 5 only; `comp_sync` = `hsync & vsync` throughout.
- **Streaming:** push indices 0..7 repeatedly and keep the FIFO non-empty → each active pixel shows the matching default palette colour (index 3 gives FF/00/00); `underflow` stays 0; `pix_ready` drops when 16 entries are queued.
- **Underflow:** push only 5 indices, then stop → pixels 6–8 are 000000; `underflow` = 1 and stays 1 until `underflow_clr` is pulsed; set and clear in the same cycle leaves it 1.
- **Palette write:** write entry 2 = 123456 in the same cycle as an index-2 lookup → the old value 0000FF is output; the next index-2 pixel outputs 12/34/56.
- **Reset mid-frame:** assert `rst` at `vc`=2, `hc`=5 with the FIFO holding 6 entries → FIFO is empty (`pix_ready`=1), palette entry 2 is back to 0000FF, and the raster restarts at (0,0).
